// File: rtl/mysystem_pio_pkg.sv
// Shared constants for the control PIO: register word map, edge-capture modes
// and the pulse-counter sizing helper.
package mysystem_pio_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_SET          = 3'd1;
  localparam logic [2:0] ADDR_CLEAR        = 3'd2;
  localparam logic [2:0] ADDR_PULSE        = 3'd3;
  localparam logic [2:0] ADDR_IN           = 3'd4;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd5;
  localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd6;
  localparam logic [2:0] ADDR_STATUS       = 3'd7;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Counter must hold the full load value PULSE_LEN.
  function automatic int pulse_cnt_width(input int len);
    return (len < 1) ? 1 : $clog2(len + 1);
  endfunction

endpackage

// File: rtl/mysystem_pio_edge_detect.sv
// Input side of the PIO: two-flop synchroniser, edge detector and sticky
// edge-capture register with write-1-to-clear.
module mysystem_pio_edge_detect
  import mysystem_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_async_i,
  input  logic [WIDTH-1:0] clear_i,
  output logic [WIDTH-1:0] sync_in_o,
  output logic [WIDTH-1:0] edge_capture_o
);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [WIDTH-1:0] edge_hit;

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_hit = ~sync2_q & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edge_hit = sync2_q ^ prev_q;
    end else begin : g_rise
      assign edge_hit = sync2_q & ~prev_q;
    end
  endgenerate

  // A fresh edge wins over a simultaneous clear of the same bit.
  always_comb begin
    capture_d = (capture_q & ~clear_i) | edge_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      capture_q <= '0;
    end else begin
      sync1_q   <= in_async_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      capture_q <= capture_d;
    end
  end

  assign sync_in_o      = sync2_q;
  assign edge_capture_o = capture_q;

endmodule

// File: rtl/mysystem_ctrl_pio.sv
// Avalon-MM control PIO: output register with set/clear aliases, one-shot pulse
// timer OR'd onto the outputs, and an edge-capturing input port with level irq.
module mysystem_ctrl_pio
  import mysystem_pio_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] DATA_RESET = '0,
  parameter int               PULSE_LEN  = 4,
  parameter int               EDGE_TYPE  = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam int               CNT_W    = pulse_cnt_width(PULSE_LEN);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN);

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] pulse_mask_q, pulse_mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] pulse_merge;
  logic [WIDTH-1:0] capture_clear;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_capture;
  logic             pulse_busy;
  logic [WIDTH-1:0] rd_word;

  assign wr          = chipselect & ~write_n;
  assign wd          = writedata[WIDTH-1:0];
  assign pulse_busy  = (cnt_q != '0);
  assign pulse_merge = pulse_mask_q | wd;

  generate
    if (WIDTH < 32) begin : g_unused_hi
      logic unused_wd_hi;
      assign unused_wd_hi = ^writedata[31:WIDTH];
    end
  endgenerate

  always_comb begin
    data_d     = data_q;
    irq_mask_d = irq_mask_q;
    if (wr) begin
      case (address)
        ADDR_DATA:     data_d     = wd;
        ADDR_SET:      data_d     = data_q | wd;
        ADDR_CLEAR:    data_d     = data_q & ~wd;
        ADDR_IRQ_MASK: irq_mask_d = wd;
        default: ;
      endcase
    end
  end

  // One shared timer: any PULSE write with a non-empty resulting mask restarts it.
  always_comb begin
    pulse_mask_d = pulse_mask_q;
    cnt_d        = cnt_q;
    if (wr && (address == ADDR_PULSE) && (pulse_merge != '0)) begin
      pulse_mask_d = pulse_merge;
      cnt_d        = CNT_LOAD;
    end else if (pulse_busy) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        pulse_mask_d = '0;
      end
    end
  end

  assign capture_clear = (wr && (address == ADDR_EDGE_CAPTURE)) ? wd : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q       <= DATA_RESET;
      pulse_mask_q <= '0;
      cnt_q        <= '0;
      irq_mask_q   <= '0;
    end else begin
      data_q       <= data_d;
      pulse_mask_q <= pulse_mask_d;
      cnt_q        <= cnt_d;
      irq_mask_q   <= irq_mask_d;
    end
  end

  mysystem_pio_edge_detect #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge (
    .clk            (clk),
    .rst_n          (reset_n),
    .in_async_i     (in_port),
    .clear_i        (capture_clear),
    .sync_in_o      (sync_in),
    .edge_capture_o (edge_capture)
  );

  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_DATA:         rd_word = data_q;
      ADDR_PULSE:        rd_word = pulse_mask_q;
      ADDR_IN:           rd_word = sync_in;
      ADDR_IRQ_MASK:     rd_word = irq_mask_q;
      ADDR_EDGE_CAPTURE: rd_word = edge_capture;
      ADDR_STATUS:       rd_word = WIDTH'(pulse_busy);
      default:           rd_word = '0;
    endcase
  end

  always_comb begin
    readdata              = '0;
    readdata[WIDTH-1:0]   = rd_word;
  end

  assign out_port = data_q | pulse_mask_q;
  assign irq      = |(edge_capture & irq_mask_q);

endmodule

// File: tb/tb_mysystem_ctrl_pio.sv
// Bench for the control PIO: directed vector table, async-reset sequence and
// randomized traffic checked against a cycle-level reference model.
module tb_mysystem_ctrl_pio;

  localparam int         WIDTH      = 8;
  localparam logic [7:0] DATA_RESET = 8'hA5;
  localparam int         PULSE_LEN  = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic        irq;

  always #5 clk = ~clk;

  mysystem_ctrl_pio #(
    .WIDTH      (WIDTH),
    .DATA_RESET (DATA_RESET),
    .PULSE_LEN  (PULSE_LEN),
    .EDGE_TYPE  (0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .irq        (irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", name, got, exp);
    else n_pass++;
  endtask

  // Reference model: pulse end kept as an absolute deadline, inputs as a
  // history of sampled values (newest first).
  logic [7:0] m_data, m_pmask, m_irqmask, m_cap;
  int         m_cyc, m_deadline;
  logic [7:0] m_samp[$];

  task automatic model_reset();
    m_data = DATA_RESET; m_pmask = '0; m_irqmask = '0; m_cap = '0;
    m_cyc = 0; m_deadline = 0;
    m_samp = '{8'h00, 8'h00, 8'h00};
  endtask

  task automatic model_step(input logic [2:0] a, input logic cs, input logic wn,
                            input logic [31:0] wd, input logic [7:0] ip);
    logic       w_en;
    logic [7:0] w;
    logic [7:0] rise;
    w_en = cs && !wn;
    w    = wd[7:0];
    m_cyc++;
    // Change seen two edges ago vs three edges ago reaches the capture now.
    rise = m_samp[1] & ~m_samp[2];
    if (w_en) begin
      case (a)
        3'd0: m_data = w;
        3'd1: m_data = m_data | w;
        3'd2: m_data = m_data & ~w;
        3'd5: m_irqmask = w;
        default: ;
      endcase
    end
    if (w_en && a == 3'd3 && ((m_pmask | w) != 8'h00)) begin
      m_pmask    = m_pmask | w;
      m_deadline = m_cyc + PULSE_LEN;
    end else if (m_cyc >= m_deadline) begin
      m_pmask = '0;
    end
    m_cap = (m_cap & ~((w_en && a == 3'd6) ? w : 8'h00)) | rise;
    m_samp.push_front(ip);
    void'(m_samp.pop_back());
  endtask

  function automatic logic [31:0] model_rd(input logic [2:0] a);
    case (a)
      3'd0: return {24'h0, m_data};
      3'd3: return {24'h0, m_pmask};
      3'd4: return {24'h0, m_samp[1]};
      3'd5: return {24'h0, m_irqmask};
      3'd6: return {24'h0, m_cap};
      3'd7: return {31'h0, (m_deadline > m_cyc)};
      default: return 32'h0;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [7:0]  inp;
    logic [7:0]  exp_out;
    logic        exp_irq;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd,
                     input logic [7:0] ip, input logic [7:0] eo, input logic ei, input logic [31:0] er);
    vecs.push_back('{addr: a, cs: cs, wn: wn, wd: wd, inp: ip, exp_out: eo, exp_irq: ei, exp_rd: er});
  endtask

  task automatic drive(input logic [2:0] a, input logic cs, input logic wn,
                       input logic [31:0] wd, input logic [7:0] ip);
    address = a; chipselect = cs; write_n = wn; writedata = wd; in_port = ip;
  endtask

  task automatic cycle(input logic [2:0] a, input logic cs, input logic wn,
                       input logic [31:0] wd, input logic [7:0] ip);
    drive(a, cs, wn, wd, ip);
    @(posedge clk);
    model_step(a, cs, wn, wd, ip);
    #1;
  endtask

  initial begin
    logic [7:0]  r_inp;
    logic [2:0]  r_a;
    logic        r_cs, r_wn;
    logic [31:0] r_wd;

    reset_n = 1'b0;
    drive(3'd0, 1'b0, 1'b1, 32'h0, 8'h00);
    model_reset();

    // addr cs wn wd inp | out irq rd
    add(0,1,1,32'h0,        8'h00, 8'hA5,0,32'hA5);
    add(0,1,0,32'hFFFFFF3C, 8'h00, 8'h3C,0,32'h3C);
    add(1,1,0,32'h81,       8'h00, 8'hBD,0,32'h0);
    add(2,1,0,32'h0C,       8'h00, 8'hB1,0,32'h0);
    add(0,1,1,32'h0,        8'h00, 8'hB1,0,32'hB1);
    add(4,1,0,32'hFF,       8'h00, 8'hB1,0,32'h0);
    add(7,1,0,32'hFF,       8'h00, 8'hB1,0,32'h0);
    add(0,1,0,32'h00,       8'h00, 8'h00,0,32'h0);
    add(3,1,0,32'h02,       8'h00, 8'h02,0,32'h02);
    add(7,1,1,32'h0,        8'h00, 8'h02,0,32'h1);
    add(7,1,1,32'h0,        8'h00, 8'h02,0,32'h1);
    add(7,1,1,32'h0,        8'h00, 8'h02,0,32'h1);
    add(7,1,1,32'h0,        8'h00, 8'h00,0,32'h0);
    add(3,1,0,32'h00,       8'h00, 8'h00,0,32'h0);
    add(7,1,1,32'h0,        8'h00, 8'h00,0,32'h0);
    add(3,1,0,32'h02,       8'h00, 8'h02,0,32'h02);
    add(7,1,1,32'h0,        8'h00, 8'h02,0,32'h1);
    add(3,1,0,32'h04,       8'h00, 8'h06,0,32'h06);
    add(7,1,1,32'h0,        8'h00, 8'h06,0,32'h1);
    add(7,1,1,32'h0,        8'h00, 8'h06,0,32'h1);
    add(7,1,1,32'h0,        8'h00, 8'h06,0,32'h1);
    add(7,1,1,32'h0,        8'h00, 8'h00,0,32'h0);
    add(5,1,0,32'h01,       8'h00, 8'h00,0,32'h01);
    add(6,1,1,32'h0,        8'h01, 8'h00,0,32'h0);
    add(4,1,1,32'h0,        8'h01, 8'h00,0,32'h01);
    add(6,1,1,32'h0,        8'h01, 8'h00,1,32'h01);
    add(6,1,1,32'h0,        8'h00, 8'h00,1,32'h01);
    add(6,1,1,32'h0,        8'h00, 8'h00,1,32'h01);
    add(6,1,1,32'h0,        8'h00, 8'h00,1,32'h01);
    add(4,1,1,32'h0,        8'h00, 8'h00,1,32'h0);
    add(6,1,0,32'h01,       8'h00, 8'h00,0,32'h0);
    add(6,1,1,32'h0,        8'h01, 8'h00,0,32'h0);
    add(6,1,1,32'h0,        8'h01, 8'h00,0,32'h0);
    add(6,1,0,32'h01,       8'h01, 8'h00,1,32'h01);
    add(6,1,1,32'h0,        8'h01, 8'h00,1,32'h01);
    add(0,1,0,32'h10,       8'h01, 8'h10,1,32'h10);
    add(3,1,0,32'h11,       8'h01, 8'h11,1,32'h11);
    add(7,1,1,32'h0,        8'h01, 8'h11,1,32'h1);
    add(7,1,1,32'h0,        8'h01, 8'h11,1,32'h1);
    add(7,1,1,32'h0,        8'h01, 8'h11,1,32'h1);
    add(7,1,1,32'h0,        8'h01, 8'h10,1,32'h0);
    add(0,0,0,32'hFF,       8'h01, 8'h10,1,32'h10);
    add(0,1,1,32'hFF,       8'h01, 8'h10,1,32'h10);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].addr, vecs[i].cs, vecs[i].wn, vecs[i].wd, vecs[i].inp);
      check($sformatf("vec%0d.out_port", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
      check($sformatf("vec%0d.irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
      check($sformatf("vec%0d.readdata", i), readdata, vecs[i].exp_rd);
      $display("vec %0d addr=%0d wr=%0b wd=%h in=%h -> out=%h irq=%0b rd=%h",
               i, vecs[i].addr, vecs[i].cs & ~vecs[i].wn, vecs[i].wd, vecs[i].inp, out_port, irq, readdata);
      @(negedge clk);
    end

    // Reset asserted mid-pulse with a captured edge pending.
    cycle(3'd3, 1'b1, 1'b0, 32'h08, 8'h00);
    check("rst.pre_out", {24'h0, out_port}, 32'h18);
    check("rst.pre_irq", {31'h0, irq}, 32'h1);
    @(negedge clk);
    drive(3'd7, 1'b0, 1'b1, 32'h0, 8'h00);
    #2 reset_n = 1'b0;
    #1;
    check("rst.async_out", {24'h0, out_port}, {24'h0, DATA_RESET});
    check("rst.async_irq", {31'h0, irq}, 32'h0);
    $display("async reset: out=%h irq=%0b", out_port, irq);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle(3'd7, 1'b0, 1'b1, 32'h0, 8'h00);
      check($sformatf("post_rst%0d.out", k), {24'h0, out_port}, {24'h0, DATA_RESET});
      check($sformatf("post_rst%0d.status", k), readdata, 32'h0);
      check($sformatf("post_rst%0d.irq", k), {31'h0, irq}, 32'h0);
      $display("post-reset %0d: out=%h status=%h irq=%0b", k, out_port, readdata, irq);
      @(negedge clk);
    end

    // Randomized traffic against the reference model.
    r_inp = 8'h00;
    for (int k = 0; k < 400; k++) begin
      r_a  = 3'($urandom_range(0, 7));
      r_cs = ($urandom_range(0, 3) != 0);
      r_wn = 1'($urandom_range(0, 1));
      r_wd = $urandom;
      if ($urandom_range(0, 3) == 0) r_inp = 8'($urandom);
      cycle(r_a, r_cs, r_wn, r_wd, r_inp);
      check($sformatf("rnd%0d.out_port", k), {24'h0, out_port}, {24'h0, m_data | m_pmask});
      check($sformatf("rnd%0d.irq", k), {31'h0, irq}, {31'h0, |(m_cap & m_irqmask)});
      check($sformatf("rnd%0d.readdata", k), readdata, model_rd(r_a));
      $display("rnd %0d addr=%0d wr=%0b wd=%h in=%h -> out=%h irq=%0b rd=%h",
               k, r_a, r_cs & ~r_wn, r_wd, r_inp, out_port, irq, readdata);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mysystem_ctrl_pio.md
Name: mysystem_ctrl_pio

Overview:
Parametrised Avalon-MM slave PIO, the next generation of the single-bit output port. Provides:
- a WIDTH-bit output register with atomic set/clear aliases;
- a retriggerable one-shot pulse generator OR'd onto the outputs;
- a synchronised WIDTH-bit input port with edge capture and a maskable level interrupt.

It sits on the system interconnect next to the existing PIOs and drives control strobes and lines such as stop and start.

Parameters:
WIDTH, 8, output and input bit count, 1..32.
DATA_RESET, 0, reset value of the DATA register (WIDTH bits).
PULSE_LEN, 4, pulse duration in clk cycles, must be >= 1.
EDGE_TYPE, 0, capture condition: 0 = rising, 1 = falling, 2 = any edge.

Ports:
clk  in  1  system clock; every register is clocked on the rising edge.
reset_n  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk upstream.
address  in  3  register word address.
chipselect  in  1  slave select.
write_n  in  1  active-low write strobe, qualified by chipselect.
writedata  in  32  write data; bits above WIDTH are ignored.
readdata  out  32  combinational read data, zero wait states; bits above WIDTH read 0.
in_port  in  WIDTH  asynchronous input lines.
out_port  out  WIDTH  data_out | pulse_mask.
irq  out  1  level interrupt, |(edge_capture & irq_mask).

Behaviour:
- Write strobe: wr = chipselect & ~write_n. Read latency is 0 (readdata is combinational on address).
- Register map:
  - 0 DATA (RW): write loads data_out; read returns data_out.
  - 1 SET (WO): data_out <= data_out | wd. Reads 0.
  - 2 CLEAR (WO): data_out <= data_out & ~wd. Reads 0.
  - 3 PULSE (RW): write ORs wd into pulse_mask and reloads the counter to PULSE_LEN. Read returns pulse_mask.
  - 4 IN (RO): returns the synchronised input sync2.
  - 5 IRQ_MASK (RW).
  - 6 EDGE_CAPTURE (R/W1C): write 1 clears that bit.
  - 7 STATUS (RO): bit0 = pulse_busy; other bits 0.
- Reset values:
  - data_out = DATA_RESET;
  - pulse_mask = 0 and counter = 0;
  - sync1, sync2 and prev = 0;
  - irq_mask = 0 and edge_capture = 0.
  - Resulting outputs: out_port = DATA_RESET, irq = 0.
- Write latency: a DATA/SET/CLEAR write at edge T is visible on out_port after edge T.
- Pulse sequencing:
  - pulse_busy = (counter != 0).
  - A PULSE write at edge T gives pulse bits high on out_port for exactly PULSE_LEN cycles, edges T..T+PULSE_LEN.
  - Each cycle while busy, the counter decrements. When it goes from 1 to 0, pulse_mask clears on that same edge.
  - Counter width is $clog2(PULSE_LEN+1).
- Pulse retrigger: a PULSE write while busy ORs in the new bits and reloads the counter to PULSE_LEN. The old bits are extended too; there is one shared timer.
- Pulse write of 0: reloads the counter only if pulse_mask is non-zero. If pulse_mask is zero, the counter stays 0.
- Pulse vs DATA: a pulse bit that is already 1 in DATA stays 1 after the pulse ends.
- Input synchroniser: in_port -> sync1 -> sync2 -> prev, each one register stage.
- Edge detection, combinational from sync2 and prev:
  - rising = sync2 & ~prev;
  - falling = ~sync2 & prev;
  - any = sync2 ^ prev.
- Edge latency: an in_port change sampled at edge N sets its edge_capture bit at edge N+2. irq follows combinationally.
- Edge capture is sticky until cleared by W1C. For a simultaneous new edge and W1C on the same bit, the new edge wins and the bit stays set.
- Writes to read-only addresses (4, 7) have no effect.
- Reset asserted mid-pulse: out_port returns to DATA_RESET immediately (asynchronously) and any pending edge captures are lost.

Decomposition:
- Package mysystem_pio_pkg holds:
  - register address localparams ADDR_DATA..ADDR_STATUS;
  - EDGE_RISE / EDGE_FALL / EDGE_ANY constants;
  - the pulse-counter width function.
- One sub-module, mysystem_pio_edge_detect (parameters WIDTH, EDGE_TYPE), contains:
  - the two-flop synchroniser, prev register and edge logic;
  - the edge_capture register with W1C and set-priority.
  - It outputs sync_in and edge_capture.
- The top level holds the register decode, data_out, the pulse timer and the read mux.

Test Plan:
- Reset with DATA_RESET=8'hA5: after reset_n release, out_port=8'hA5, irq=0, readdata at addr 0 = 32'h000000A5. Then write DATA=8'h3C -> out_port=8'h3C next cycle.
- From DATA=8'h3C: SET 8'h81 -> 8'hBD; CLEAR 8'h0C -> 8'hB1. Reading addr 1 or 2 returns 0.
- PULSE_LEN=4, DATA=0: write PULSE=8'h02 at edge T -> out_port=8'h02 for 4 cycles, then 8'h00; STATUS bit0 =1 during, 0 after. Retrigger with 8'h04 at T+2 -> out_port=8'h06 until T+6, then 0.
- EDGE_TYPE=0, IRQ_MASK=8'h01: raise in_port[0] sampled at edge N -> EDGE_CAPTURE bit0 set at N+2 and irq=1. Read IN returns 8'h01. Falling edge causes no new capture.
- W1C: write EDGE_CAPTURE=8'h01 -> irq=0. Then repeat the W1C in the same cycle a new captured edge arrives -> bit remains 1, irq=1.
- Reset asserted mid-pulse with edge captured: out_port=DATA_RESET and irq=0 asynchronously. After release, no residual pulse and STATUS=0.
